// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one 6-lane sort engine between NREQ requesters, one job in flight.
// Latency: start 1 cycle after grant, rsp_valid at grant+2+SORT_LAT; response held until rsp_ready, req_ready low outside IDLE.
module sort_job_scheduler #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int SORT_LAT = 1,
    parameter int TIMEOUT  = 15,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int VW      = 6 * W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*VW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [VW-1:0]        rsp_data,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic                 srt_start,
    output logic [VW-1:0]        srt_data,
    input  logic                 srt_done,
    input  logic [VW-1:0]        srt_result,
    output logic                 busy,
    output logic [15:0]          job_count
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [VW-1:0]   rdat_q, rdat_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic [15:0]     jobs_q, jobs_d;

    logic            found;
    logic [IDW-1:0]  gnt_idx;
    logic [VW-1:0]   gnt_vec;
    int              j;

    // Round-robin search starting at rr_q.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(rr_q) + i) % NREQ;
            if (!found && req_valid[j]) begin
                found   = 1'b1;
                gnt_idx = IDW'(j);
                gnt_vec = req_data[j*VW +: VW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        vec_d   = vec_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        jobs_d  = jobs_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    id_d    = gnt_idx;
                    vec_d   = gnt_vec;
                    rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q < CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Early done is a sticky leftover from the previous job, so it is ignored.
                if (cnt_q >= CW'(SORT_LAT) && srt_done) begin
                    rdat_d  = srt_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    jobs_d  = jobs_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            vec_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            jobs_q  <= jobs_d;
        end
    end

    assign req_ready = (state_q == S_IDLE && found && !rst) ? (NREQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rdat_q;
    assign rsp_err   = err_q;
    assign srt_start = start_q;
    assign srt_data  = vec_q;
    assign busy      = (state_q != S_IDLE);
    assign job_count = jobs_q;
endmodule

// File: tb/tb_sort_job_scheduler.sv
// Bench for sort_job_scheduler: behavioural sticky-done sort engine plus response scoreboard.
// Runs single job, stale done, fairness, backpressure, timeout and reset-in-WAIT scenarios.
module tb_sort_job_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int VW   = 6 * W;
    localparam int SLAT = 3;
    localparam int TOUT = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*VW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [VW-1:0]   rsp_data;
    logic            rsp_err;
    logic            rsp_ready;
    logic            srt_start;
    logic [VW-1:0]   srt_data;
    logic            srt_done;
    logic [VW-1:0]   srt_result;
    logic            busy;
    logic [15:0]     job_count;

    sort_job_scheduler #(.NREQ(NREQ), .W(W), .SORT_LAT(SLAT), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .srt_start(srt_start), .srt_data(srt_data), .srt_done(srt_done), .srt_result(srt_result),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [VW-1:0] dat;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_jobs = 0;

    function automatic logic [VW-1:0] sort6(input logic [VW-1:0] v);
        logic [W-1:0] a[6];
        logic [W-1:0] t;
        logic [VW-1:0] r;
        for (int i = 0; i < 6; i++) a[i] = v[i*W +: W];
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 5 - i; k++)
                if (a[k] > a[k+1]) begin
                    t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                end
        r = '0;
        for (int i = 0; i < 6; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    // Engine model: result appears two edges after start; done is sticky and never clears.
    logic          eng_done = 1'b0;
    logic          eng_alive = 1'b1;
    logic [VW-1:0] eng_res = '0;
    logic [VW-1:0] e_vec = '0;
    int            e_cnt = 0;
    always @(posedge clk) begin
        if (srt_start) begin
            e_cnt <= 2;
            e_vec <= srt_data;
        end else if (e_cnt != 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1) begin
                eng_done <= 1'b1;
                eng_res  <= sort6(e_vec);
            end
        end
    end
    assign srt_done   = eng_done & eng_alive;
    assign srt_result = eng_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_one(input int k, input logic [VW-1:0] v);
        req_data[k*VW +: VW] = v;
        req_valid = 4'b0001 << k;
        tick();
        req_valid = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic collect(input int n, input int budget);
        int   got = 0;
        int   cyc = 0;
        int   g;
        exp_t e;
        while (got < n && cyc < budget) begin
            #1;
            if (gq.size() > 0 && (req_valid & req_ready) != 0) begin
                g = gq.pop_front();
                n_vec++;
                if (req_ready !== (4'b0001 << g)) begin
                    n_bad++;
                    $display("FAIL grant_order got=%b exp=%b", req_ready, 4'b0001 << g);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected id=%0d data=%h", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.dat, e.err}) begin
                        n_bad++;
                        $display("FAIL rsp got id=%0d data=%h err=%b exp id=%0d data=%h err=%b",
                                 rsp_id, rsp_data, rsp_err, e.id, e.dat, e.err);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (got < n) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout got=%0d exp=%0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy, rsp_valid, srt_start, rsp_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b exp=0000", {busy, rsp_valid, srt_start, rsp_err});
        end
        n_vec++;
        if ({job_count, srt_data, rsp_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got jc=%h sd=%h rd=%h exp 0", job_count, srt_data, rsp_data);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        exp_jobs = 0;
    endtask

    task automatic test_single();
        logic [VW-1:0] v = 48'h02_07_01_09_03_05;
        int lat;
        rsp_ready = 1'b1;
        req_data[0 +: VW] = v;
        req_valid = 4'b0001;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        sb.push_back('{id: 2'd0, dat: 48'h09_07_05_03_02_01, err: 1'b0});
        @(posedge clk);
        #1;
        req_valid = '0;
        n_vec++;
        if ({busy, srt_start, srt_data} !== {1'b1, 1'b1, v}) begin
            n_bad++;
            $display("FAIL single_issue got busy=%b start=%b data=%h exp 1 1 %h", busy, srt_start, srt_data, v);
        end
        wait_rsp(lat);
        n_vec++;
        if (lat !== SLAT + 1) begin
            n_bad++;
            $display("FAIL single_latency got=%0d exp=%0d", lat, SLAT + 1);
        end
        collect(1, 5);
        exp_jobs++;
        n_vec++;
        if ({busy, job_count} !== {1'b0, 16'(exp_jobs)}) begin
            n_bad++;
            $display("FAIL single_done got busy=%b jc=%0d exp busy=0 jc=%0d", busy, job_count, exp_jobs);
        end
    endtask

    task automatic test_stale_done();
        logic [VW-1:0] v = 48'h10_80_20_FF_00_40;
        int lat;
        grant_one(3, v);
        sb.push_back('{id: 2'd3, dat: 48'hFF_80_40_20_10_00, err: 1'b0});
        wait_rsp(lat);
        n_vec++;
        if (lat !== SLAT + 1) begin
            n_bad++;
            $display("FAIL stale_latency got=%0d exp=%0d", lat, SLAT + 1);
        end
        collect(1, 5);
        exp_jobs++;
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 2, 3, 0, 1};
        logic [VW-1:0] v;
        for (int k = 0; k < NREQ; k++) begin
            v = {8'(k * 7 + 3), 8'(200 - k), 8'(k), 8'(90 + k), 8'(17), 8'(255 - k * 11)};
            req_data[k*VW +: VW] = v;
        end
        for (int i = 0; i < 6; i++) begin
            gq.push_back(order[i]);
            sb.push_back('{id: 2'(order[i]), dat: sort6(req_data[order[i]*VW +: VW]), err: 1'b0});
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        collect(6, 200);
        req_valid = '0;
        exp_jobs += 6;
        gq.delete();
        n_vec++;
        if (job_count !== 16'(exp_jobs)) begin
            n_bad++;
            $display("FAIL fair_jobs got=%0d exp=%0d", job_count, exp_jobs);
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v = 48'h33_11_66_22_55_44;
        int lat;
        int bad = 0;
        rsp_ready = 1'b0;
        grant_one(2, v);
        sb.push_back('{id: 2'd2, dat: 48'h66_55_44_33_22_11, err: 1'b0});
        req_valid = 4'b1011;
        wait_rsp(lat);
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_rsp_timeout got=%b exp=1", rsp_valid);
        end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if ({rsp_valid, req_ready, rsp_id, rsp_data, rsp_err} !==
                {1'b1, 4'b0000, sb[0].id, sb[0].dat, sb[0].err}) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b id=%0d d=%h e=%b exp v=1 rdy=0000 id=%0d d=%h e=%b",
                         c, rsp_valid, req_ready, rsp_id, rsp_data, rsp_err, sb[0].id, sb[0].dat, sb[0].err);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        collect(1, 5);
        exp_jobs++;
        n_vec++;
        if ({busy, job_count} !== {1'b0, 16'(exp_jobs)}) begin
            n_bad++;
            $display("FAIL bp_idle got busy=%b jc=%0d exp busy=0 jc=%0d", busy, job_count, exp_jobs);
        end
    endtask

    task automatic test_timeout();
        int lat;
        eng_alive = 1'b0;
        rsp_ready = 1'b1;
        grant_one(1, 48'h01_02_03_04_05_06);
        sb.push_back('{id: 2'd1, dat: '0, err: 1'b1});
        wait_rsp(lat);
        n_vec++;
        if (lat !== TOUT + 1) begin
            n_bad++;
            $display("FAIL timeout_latency got=%0d exp=%0d", lat, TOUT + 1);
        end
        collect(1, 5);
        exp_jobs++;
        n_vec++;
        if (job_count !== 16'(exp_jobs)) begin
            n_bad++;
            $display("FAIL timeout_jobs got=%0d exp=%0d", job_count, exp_jobs);
        end
        eng_alive = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        rsp_ready = 1'b1;
        grant_one(1, 48'hAA_BB_CC_DD_EE_FF);
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, srt_start, rsp_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_wait_ctl got=%b exp=000", {busy, srt_start, rsp_valid});
        end
        tick();
        tick();
        rst = 1'b0;
        exp_jobs = 0;
        n_vec++;
        if (job_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_wait_jobs got=%0d exp=0", job_count);
        end
        for (int k = 0; k < NREQ; k++) req_data[k*VW +: VW] = {8'(k), 8'(9), 8'(4), 8'(k + 50), 8'(1), 8'(33)};
        gq.push_back(0);
        sb.push_back('{id: 2'd0, dat: sort6(req_data[0 +: VW]), err: 1'b0});
        req_valid = 4'b1111;
        collect(1, 30);
        req_valid = '0;
        exp_jobs++;
        gq.delete();
        n_vec++;
        if (job_count !== 16'(exp_jobs)) begin
            n_bad++;
            $display("FAIL rst_wait_after got=%0d exp=%0d", job_count, exp_jobs);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale_done();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expected got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
